// File: rtl/div4b_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div4b_seq_pkg
//  Purpose  : Shared definitions for the sequential restoring divider:
//             FSM state encodings and the iteration-counter width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package div4b_seq_pkg;

   // FSM state encodings shared by the divider and anything that decodes it.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of the iteration counter, which must hold 0..WIDTH-1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div4b_seq_resta4b.sv
`default_nettype none
// ============================================================================
//  Module   : resta4b
//  Purpose  : Combinational ripple-borrow subtractor d = a - b, built from a
//             chain of 1-bit full-subtractor cells (borrow-in -> borrow-out),
//             the subtractive mirror of the ripple-carry adder chain.
//  Ports    : a  [N-1:0] in  - minuend
//             b  [N-1:0] in  - subtrahend
//             d  [N-1:0] out - difference (modulo 2^N)
//             bo         out - final borrow (1 when a < b)
//  Revision : 1.0 - initial release
// ============================================================================
module resta4b #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] d,
   output logic         bo
);

   logic [N:0] w_borrow;

   assign w_borrow[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         // Full-subtractor cell: borrow out when a < b + bi at this bit.
         assign d[gi]          = a[gi] ^ b[gi] ^ w_borrow[gi];
         assign w_borrow[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & w_borrow[gi]);
      end
   endgenerate

   assign bo = w_borrow[N];

endmodule
`default_nettype wire

// File: rtl/div4b_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div4b_seq
//  Purpose  : Sequential restoring divider for unsigned WIDTH-bit operands.
//             One shift-and-trial-subtract step per clock; results after
//             WIDTH steps, flagged by a one-cycle done pulse.
//  Ports    : clk       in  - rising-edge clock
//             rst       in  - asynchronous active-high reset
//             start     in  - request pulse, sampled when not busy
//             dividend  in  - numerator, captured on accepted start
//             divisor   in  - denominator, captured on accepted start
//             busy      out - operation in progress
//             done      out - one-cycle pulse, results valid
//             quotient  out - registered quotient
//             remainder out - registered remainder
//             div_zero  out - divide-by-zero flag, valid with done
//  Options  : DIV4B_ZERO_CHECK_EN - divisor==0 finishes after one cycle and
//             raises div_zero; otherwise div_zero is tied low and a zero
//             divisor runs the full iteration.
//  Revision : 1.0 - initial release
// ============================================================================
module div4b_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   import div4b_seq_pkg::*;

   localparam int unsigned c_cnt_w = cnt_width(WIDTH);

   state_t                 r_state;
   logic [c_cnt_w-1:0]     r_count;
   logic [WIDTH:0]         r_r;
   logic [WIDTH-1:0]       r_q;
   logic [WIDTH-1:0]       r_d;
   logic                   r_busy;
   logic                   r_done;
   logic [WIDTH-1:0]       r_quot;
   logic [WIDTH-1:0]       r_rem;

   logic [2*WIDTH:0]       w_shift;
   logic [WIDTH:0]         w_diff;
   logic                   w_borrow;
   logic [WIDTH:0]         w_r_next;
   logic [WIDTH-1:0]       w_q_next;

   // {R,Q} shifted left as one register pair; R's MSB falls off the top.
   assign w_shift = {r_r, r_q} << 1;

   resta4b #(
      .N (WIDTH + 1)
   ) u_resta (
      .a  (w_shift[2*WIDTH:WIDTH]),
      .b  ({1'b0, r_d}),
      .d  (w_diff),
      .bo (w_borrow)
   );

   // Restore on borrow (keep shifted R), otherwise commit the difference.
   assign w_r_next = w_borrow ? w_shift[2*WIDTH:WIDTH] : w_diff;
   assign w_q_next = w_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, ~w_borrow};

`ifdef DIV4B_ZERO_CHECK_EN
   logic r_dz;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_count <= '0;
         r_r     <= '0;
         r_q     <= '0;
         r_d     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
`ifdef DIV4B_ZERO_CHECK_EN
         r_dz    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_r     <= '0;
                  r_q     <= dividend;
                  r_d     <= divisor;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
`ifdef DIV4B_ZERO_CHECK_EN
                  r_dz    <= 1'b0;
`endif
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end

            ST_RUN: begin
`ifdef DIV4B_ZERO_CHECK_EN
               // Zero divisor finishes on the first RUN edge; r_q still
               // holds the untouched dividend at this point.
               if (r_d == '0) begin
                  r_quot  <= '1;
                  r_rem   <= r_q;
                  r_dz    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else
`endif
               begin
                  r_r     <= w_r_next;
                  r_q     <= w_q_next;
                  r_count <= r_count + c_cnt_w'(1);
                  if (r_count == c_cnt_w'(WIDTH - 1)) begin
                     r_quot  <= w_q_next;
                     r_rem   <= w_r_next[WIDTH-1:0];
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign quotient  = r_quot;
   assign remainder = r_rem;

`ifdef DIV4B_ZERO_CHECK_EN
   assign div_zero = r_dz;
`else
   assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div4b_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div4b_seq
//  Purpose  : Directed self-checking bench for div4b_seq (WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div4b_seq;

   localparam int W = 4;

`ifdef DIV4B_ZERO_CHECK_EN
   localparam int   c_zlat  = 1;
   localparam logic c_zdz   = 1'b1;
   localparam bit   c_zbusy = 1'b0;
`else
   localparam int   c_zlat  = W;
   localparam logic c_zdz   = 1'b0;
   localparam bit   c_zbusy = 1'b1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   int n_vec = 0;
   int n_err = 0;

   div4b_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation and wait (bounded) for its done pulse.
   task automatic do_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [W-1:0] qe, input logic [W-1:0] re, input int late,
                        input logic dze, input bit chk_busy);
      int lat;
      int bcnt;
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      tick();
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      chk({tag, "_done_lo"}, done, 0);
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) bcnt++;
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, late);
      if (chk_busy) chk({tag, "_busy_cycles"}, bcnt, W);
      chk({tag, "_quotient"}, quotient, qe);
      chk({tag, "_remainder"}, remainder, re);
      chk({tag, "_div_zero"}, div_zero, dze);
      chk({tag, "_busy_at_done"}, busy, 0);
   endtask

   // One edge after done: pulse must have ended and results must hold.
   task automatic post(input string tag, input logic [W-1:0] qe, input logic [W-1:0] re);
      tick();
      chk({tag, "_done_drop"}, done, 0);
      chk({tag, "_q_hold"}, quotient, qe);
      chk({tag, "_r_hold"}, remainder, re);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcnt;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dz", div_zero, 0);
      rst = 1'b0;
      tick();

      do_op("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, W, 1'b0, 1'b1);
      post("d13_3", 4'd4, 4'd1);
      do_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, W, 1'b0, 1'b1);
      post("d15_1", 4'd15, 4'd0);
      do_op("d5_7", 4'd5, 4'd7, 4'd0, 4'd5, W, 1'b0, 1'b1);
      post("d5_7", 4'd0, 4'd5);
      do_op("d0_9", 4'd0, 4'd9, 4'd0, 4'd0, W, 1'b0, 1'b1);
      post("d0_9", 4'd0, 4'd0);
      do_op("d9_0", 4'd9, 4'd0, 4'd15, 4'd9, c_zlat, c_zdz, c_zbusy);
      post("d9_0", 4'd15, 4'd9);

      // Start while running must be ignored.
      start    = 1'b1;
      dividend = 4'd12;
      divisor  = 4'd5;
      tick();
      start    = 1'b0;
      dividend = 4'd0;
      divisor  = 4'd0;
      tick();
      start    = 1'b1;
      dividend = 4'd7;
      divisor  = 4'd2;
      tick();
      start    = 1'b0;
      tick();
      chk("ign_done_early", done, 0);
      tick();
      chk("ign_done", done, 1);
      chk("ign_q", quotient, 2);
      chk("ign_r", remainder, 2);
      tick();
      chk("ign_done_drop", done, 0);
      chk("ign_no_restart", busy, 0);

      // Back-to-back: second start issued in the DONE cycle of the first.
      do_op("b2b_6_4", 4'd6, 4'd4, 4'd1, 4'd2, W, 1'b0, 1'b1);
      do_op("b2b_8_3", 4'd8, 4'd3, 4'd2, 4'd2, W, 1'b0, 1'b1);
      post("b2b_8_3", 4'd2, 4'd2);

      // Asynchronous reset in the middle of an operation.
      start    = 1'b1;
      dividend = 4'd13;
      divisor  = 4'd3;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_q", quotient, 0);
      chk("arst_r", remainder, 0);
      chk("arst_dz", div_zero, 0);
      tick();
      tick();
      rst  = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done === 1'b1) dcnt++;
      end
      chk("arst_no_done", dcnt, 0);
      do_op("d10_4", 4'd10, 4'd4, 4'd2, 4'd2, W, 1'b0, 1'b1);
      post("d10_4", 4'd2, 4'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
